bus_if_ext: RTL and testbench



---
 rtl/bus_if_ext.sv | 243 ++++++++++++++++++++++++
 tb/tb_bus_if_ext.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_if_ext.sv
// ----------------------------------------------------------------------------
// bus_if_ext
//
// CPU-side memory interface sitting between a pipeline stage and both the
// local scratch-pad memory (SPM) and the shared system bus. SPM hits finish
// combinationally in the requesting cycle. Every other slave is reached through
// a request/grant/ready bus-master FSM. The FSM supports byte enables, an
// optional one-entry posted-write buffer, a grant/ready timeout and flush abort
// of ungranted requests.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   stall, flush             pipeline control
//   busy                     CPU must hold its request
//   addr, as, rw, be,        CPU request (word address, strobe, 0=rd/1=wr,
//   wr_data                  byte enables, write data)
//   rd_data                  read data, 0 when not valid
//   err                      blocking access timed out (completion cycle/HOLD)
//   wr_err                   one-cycle pulse: posted write timed out
//   spm_*                    scratch-pad side, address/data wired through
//   bus_*                    system bus master side
//
// State table
//   state   | meaning
//   IDLE    | no bus transaction; SPM hits served, bus requests accepted
//   REQ     | bus_req high, waiting for bus_grnt
//   ACCESS  | granted; bus_as in first cycle, waiting for bus_rdy
//   HOLD    | blocking access done while stalled; rd_data/err held
// ----------------------------------------------------------------------------
module bus_if_ext #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 30,
    parameter int SIDX_W    = 3,
    parameter int SPM_IDX   = 1,
    parameter int TIMEOUT   = 255,
    parameter int POSTED_WR = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  busy,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  as,
    input  logic                  rw,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  err,
    output logic                  wr_err,
    input  logic [DATA_W-1:0]     spm_rd_data,
    output logic [ADDR_W-1:0]     spm_addr,
    output logic                  spm_as,
    output logic                  spm_rw,
    output logic [DATA_W/8-1:0]   spm_be,
    output logic [DATA_W-1:0]     spm_wr_data,
    input  logic [DATA_W-1:0]     bus_rd_data,
    input  logic                  bus_rdy,
    input  logic                  bus_grnt,
    output logic                  bus_req,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic                  bus_as,
    output logic                  bus_rw,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic [DATA_W-1:0]     bus_wr_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic              TO_EN   = (TIMEOUT > 0);
    localparam logic              POST_EN = (POSTED_WR != 0);
    localparam logic [CNT_W-1:0]  TO_MAX  = CNT_W'(TIMEOUT);
    // The counter holds the number of REQ/ACCESS cycles already completed, so
    // the cycle in which it reads TIMEOUT-1 is the TIMEOUT-th cycle spent.
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]        r_state;
    logic              r_posted;
    logic              r_flushed;
    logic              r_hold_rd;
    logic              r_err_hold;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rd_buf;
    logic              r_bus_req;
    logic              r_bus_as;
    logic              r_bus_rw;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [BE_W-1:0]   r_bus_be;
    logic [DATA_W-1:0] r_bus_wr_data;
    logic              r_wr_err;

    logic [SIDX_W-1:0] w_idx;
    logic              w_is_spm;
    logic              w_spm_hit;
    logic              w_bus_hit;
    logic              w_spm_serve;
    logic              w_to_hit;
    logic              w_req_abort;
    logic              w_timeout;
    logic              w_acc_done;
    logic              w_done;
    logic              w_flushed;
    logic              w_blk_done;

    assign w_idx       = addr[ADDR_W-1 -: SIDX_W];
    assign w_is_spm    = (w_idx == SIDX_W'(SPM_IDX));
    assign w_spm_hit   = as & ~flush & w_is_spm;
    assign w_bus_hit   = as & ~flush & ~w_is_spm;
    // SPM may be used whenever the CPU is not waiting on the bus.
    assign w_spm_serve = w_spm_hit & ((r_state == S_IDLE) | r_posted);

    assign w_to_hit    = TO_EN & (r_cnt >= TO_LAST);
    // Flush beats grant and timeout for an ungranted blocking request.
    assign w_req_abort = (r_state == S_REQ) & flush & ~r_posted;
    // Grant or ready arriving in the timeout cycle wins over the timeout.
    assign w_timeout   = ((r_state == S_REQ) & ~bus_grnt & w_to_hit & ~w_req_abort)
                       | ((r_state == S_ACCESS) & ~bus_rdy & w_to_hit);
    assign w_acc_done  = (r_state == S_ACCESS) & bus_rdy;
    assign w_done      = w_acc_done | w_timeout;
    assign w_flushed   = r_flushed | flush;
    assign w_blk_done  = w_done & ~r_posted & ~w_flushed;

    assign spm_as      = w_spm_serve & ~stall;
    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_be      = be;
    assign spm_wr_data = wr_data;

    assign bus_req     = r_bus_req;
    assign bus_as      = r_bus_as;
    assign bus_rw      = r_bus_rw;
    assign bus_addr    = r_bus_addr;
    assign bus_be      = r_bus_be;
    assign bus_wr_data = r_bus_wr_data;
    assign wr_err      = r_wr_err;

    assign err = (w_blk_done & w_timeout) | ((r_state == S_HOLD) & r_err_hold);

    always_comb begin
        rd_data = '0;
        if (w_spm_serve & ~rw & ~stall)
            rd_data = spm_rd_data;
        else if (w_blk_done & w_acc_done & ~r_bus_rw)
            rd_data = bus_rd_data;
        else if ((r_state == S_HOLD) & r_hold_rd)
            rd_data = r_rd_buf;
    end

    always_comb begin
        busy = 1'b0;
        case (r_state)
            S_IDLE:           busy = w_bus_hit & ~(rw & POST_EN);
            S_REQ, S_ACCESS:  busy = r_posted ? w_bus_hit : ~w_done;
            default:          busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_posted      <= 1'b0;
            r_flushed     <= 1'b0;
            r_hold_rd     <= 1'b0;
            r_err_hold    <= 1'b0;
            r_cnt         <= '0;
            r_rd_buf      <= '0;
            r_bus_req     <= 1'b0;
            r_bus_as      <= 1'b0;
            r_bus_rw      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_be      <= '0;
            r_bus_wr_data <= '0;
            r_wr_err      <= 1'b0;
        end else begin
            r_bus_as <= 1'b0;
            r_wr_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_flushed  <= 1'b0;
                    r_hold_rd  <= 1'b0;
                    r_err_hold <= 1'b0;
                    if (w_bus_hit) begin
                        r_bus_req     <= 1'b1;
                        r_bus_addr    <= addr;
                        r_bus_rw      <= rw;
                        r_bus_be      <= be;
                        r_bus_wr_data <= wr_data;
                        r_posted      <= rw & POST_EN;
                        r_cnt         <= '0;
                        r_state       <= S_REQ;
                    end
                end
                S_REQ, S_ACCESS: begin
                    if (r_cnt != TO_MAX)
                        r_cnt <= r_cnt + CNT_W'(1);
                    if ((r_state == S_ACCESS) & flush & ~r_posted)
                        r_flushed <= 1'b1;
                    if (w_req_abort) begin
                        r_bus_req     <= 1'b0;
                        r_bus_addr    <= '0;
                        r_bus_rw      <= 1'b0;
                        r_bus_be      <= '0;
                        r_bus_wr_data <= '0;
                        r_state       <= S_IDLE;
                    end else if ((r_state == S_REQ) & bus_grnt) begin
                        r_bus_as <= 1'b1;
                        r_state  <= S_ACCESS;
                    end else if (w_done) begin
                        r_bus_req     <= 1'b0;
                        r_bus_addr    <= '0;
                        r_bus_rw      <= 1'b0;
                        r_bus_be      <= '0;
                        r_bus_wr_data <= '0;
                        r_posted      <= 1'b0;
                        if (w_acc_done & ~r_bus_rw)
                            r_rd_buf <= bus_rd_data;
                        if (r_posted) begin
                            r_wr_err <= w_timeout;
                            r_state  <= S_IDLE;
                        end else if (w_flushed | ~stall) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_hold_rd  <= w_acc_done & ~r_bus_rw;
                            r_err_hold <= w_timeout;
                            r_state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (~stall)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_if_ext.sv
module tb_bus_if_ext;

    localparam int DW = 32;
    localparam int AW = 30;

    localparam logic [AW-1:0] A_SPM = 30'h0800_0040;
    localparam logic [AW-1:0] A_B2  = 30'h1000_0010;
    localparam logic [AW-1:0] A_B3  = 30'h1800_0020;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush, busy;
    logic [AW-1:0] addr;
    logic          as, rw;
    logic [3:0]    be;
    logic [DW-1:0] wr_data, rd_data;
    logic          err, wr_err;
    logic [DW-1:0] spm_rd_data;
    logic [AW-1:0] spm_addr;
    logic          spm_as, spm_rw;
    logic [3:0]    spm_be;
    logic [DW-1:0] spm_wr_data;
    logic [DW-1:0] bus_rd_data;
    logic          bus_rdy, bus_grnt, bus_req, bus_as, bus_rw;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_be;
    logic [DW-1:0] bus_wr_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bus_if_ext #(.TIMEOUT(4), .POSTED_WR(1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .busy(busy),
        .addr(addr), .as(as), .rw(rw), .be(be), .wr_data(wr_data),
        .rd_data(rd_data), .err(err), .wr_err(wr_err),
        .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as(spm_as),
        .spm_rw(spm_rw), .spm_be(spm_be), .spm_wr_data(spm_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy(bus_rdy), .bus_grnt(bus_grnt),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_as(bus_as),
        .bus_rw(bus_rw), .bus_be(bus_be), .bus_wr_data(bus_wr_data)
    );

    typedef struct {
        logic          as_i, rw_i, stall_i, flush_i;
        logic [AW-1:0] addr_i;
        logic [DW-1:0] spm_i;
        logic          busy_e, spm_as_e;
        logic [DW-1:0] rd_e;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        #4;
    endtask

    task automatic clr_in();
        as = 0; rw = 0; stall = 0; flush = 0; be = 0; wr_data = 0; addr = 0;
        spm_rd_data = 0; bus_rd_data = 0; bus_rdy = 0; bus_grnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 0, 0, 0, A_SPM, 32'hFFFF_FFFF, 0, 0, 32'h0};
        vecs[1] = '{1, 0, 0, 0, A_SPM, 32'hA5A5_A5A5, 0, 1, 32'hA5A5_A5A5};
        vecs[2] = '{1, 0, 1, 0, A_SPM, 32'hA5A5_A5A5, 0, 0, 32'h0};
        vecs[3] = '{1, 1, 0, 0, A_SPM, 32'h1357_9BDF, 0, 1, 32'h0};
        vecs[4] = '{1, 0, 0, 1, A_SPM, 32'hA5A5_A5A5, 0, 0, 32'h0};
        vecs[5] = '{1, 0, 0, 1, A_B2,  32'hA5A5_A5A5, 0, 0, 32'h0};
        vecs[6] = '{1, 0, 0, 0, A_SPM, 32'h0F0F_1234, 0, 1, 32'h0F0F_1234};

        // reset state
        rst = 1; clr_in();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_busy", busy, 0);        chk("rst_rd_data", rd_data, 0);
        chk("rst_err", err, 0);          chk("rst_wr_err", wr_err, 0);
        chk("rst_bus_req", bus_req, 0);  chk("rst_bus_as", bus_as, 0);
        chk("rst_bus_rw", bus_rw, 0);    chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wr_data, 0); chk("rst_bus_be", bus_be, 0);
        chk("rst_spm_as", spm_as, 0);
        rst = 0;
        nxt();

        // combinational SPM/idle vectors
        for (int i = 0; i < 7; i++) begin
            clr_in();
            as = vecs[i].as_i; rw = vecs[i].rw_i; stall = vecs[i].stall_i;
            flush = vecs[i].flush_i; addr = vecs[i].addr_i;
            spm_rd_data = vecs[i].spm_i; be = 4'hC; wr_data = 32'h0BAD_0000 + i;
            samp();
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy_e);
            chk($sformatf("vec%0d_spm_as", i), spm_as, vecs[i].spm_as_e);
            chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].rd_e);
            chk($sformatf("vec%0d_spm_addr", i), spm_addr, vecs[i].addr_i);
            chk($sformatf("vec%0d_spm_wdata", i), spm_wr_data, 32'h0BAD_0000 + i);
            chk($sformatf("vec%0d_bus_req", i), bus_req, 0);
            nxt();
        end

        // blocking read: grant after 2 REQ cycles, ready in first ACCESS cycle,
        // stall asserted at ready
        clr_in(); as = 1; addr = A_B2;
        samp(); chk("brd_acc_busy", busy, 1); chk("brd_acc_req", bus_req, 0); nxt();
        for (int k = 0; k < 2; k++) begin
            samp(); chk("brd_req_busy", busy, 1); chk("brd_req_req", bus_req, 1);
            chk("brd_req_as", bus_as, 0); nxt();
        end
        bus_grnt = 1;
        samp(); chk("brd_addr", bus_addr, A_B2); chk("brd_rw", bus_rw, 0); chk("brd_gnt_busy", busy, 1); nxt();
        bus_grnt = 0; bus_rdy = 1; bus_rd_data = 32'h1234_5678; stall = 1;
        samp(); chk("brd_as", bus_as, 1); chk("brd_rdy_data", rd_data, 32'h1234_5678);
        chk("brd_rdy_busy", busy, 0); chk("brd_rdy_err", err, 0); nxt();
        bus_rdy = 0; bus_rd_data = 32'hDEAD_BEEF;
        samp(); chk("brd_hold_data", rd_data, 32'h1234_5678); chk("brd_hold_busy", busy, 0);
        chk("brd_hold_req", bus_req, 0); chk("brd_hold_as", bus_as, 0); chk("brd_hold_addr", bus_addr, 0); nxt();
        stall = 0;
        samp(); chk("brd_hold_last", rd_data, 32'h1234_5678); nxt();
        addr = A_SPM; spm_rd_data = 32'h600D_600D;
        samp(); chk("brd_idle_spm_as", spm_as, 1); chk("brd_idle_spm_data", rd_data, 32'h600D_600D); nxt();

        // minimum-latency blocking read
        clr_in(); as = 1; addr = A_B2;
        samp(); chk("min_c0_busy", busy, 1); nxt();
        bus_grnt = 1;
        samp(); chk("min_c1_busy", busy, 1); chk("min_c1_req", bus_req, 1); nxt();
        bus_grnt = 0; bus_rdy = 1; bus_rd_data = 32'hCAFE_F00D;
        samp(); chk("min_c2_data", rd_data, 32'hCAFE_F00D); chk("min_c2_busy", busy, 0); chk("min_c2_as", bus_as, 1); nxt();
        clr_in();
        samp(); chk("min_c3_req", bus_req, 0); chk("min_c3_data", rd_data, 0); nxt();

        // posted write, then SPM read and a bus read behind it
        clr_in(); as = 1; rw = 1; addr = A_B3; be = 4'b0011; wr_data = 32'h1122_3344;
        samp(); chk("pw_acc_busy", busy, 0); nxt();
        rw = 0; addr = A_SPM; spm_rd_data = 32'h5A5A_0001;
        samp(); chk("pw_be", bus_be, 4'b0011); chk("pw_rw", bus_rw, 1);
        chk("pw_wdata", bus_wr_data, 32'h1122_3344); chk("pw_req", bus_req, 1);
        chk("pw_spm_busy", busy, 0); chk("pw_spm_as", spm_as, 1); chk("pw_spm_data", rd_data, 32'h5A5A_0001); nxt();
        addr = A_B2; bus_grnt = 1;
        samp(); chk("pw_rd_busy0", busy, 1); chk("pw_rd_spm_as", spm_as, 0); nxt();
        bus_grnt = 0;
        samp(); chk("pw_rd_busy1", busy, 1); chk("pw_bus_as", bus_as, 1); nxt();
        bus_rdy = 1;
        samp(); chk("pw_rd_busy_rdy", busy, 1); chk("pw_rdy_wr_err", wr_err, 0); nxt();
        bus_rdy = 0;
        samp(); chk("pw_rd_accept_busy", busy, 1); chk("pw_rd_accept_req", bus_req, 0); chk("pw_wr_err", wr_err, 0); nxt();
        bus_grnt = 1;
        samp(); chk("pw_rd_req", bus_req, 1); chk("pw_rd_rw", bus_rw, 0); chk("pw_rd_addr", bus_addr, A_B2); nxt();
        bus_grnt = 0; bus_rdy = 1; bus_rd_data = 32'h0BAD_CAFE;
        samp(); chk("pw_rd_data", rd_data, 32'h0BAD_CAFE); chk("pw_rd_done_busy", busy, 0); nxt();
        clr_in(); nxt();

        // blocking timeout, stalled in the timeout cycle
        clr_in(); as = 1; addr = A_B2;
        samp(); chk("to_acc_busy", busy, 1); nxt();
        for (int k = 0; k < 3; k++) begin
            samp(); chk("to_wait_busy", busy, 1); chk("to_wait_err", err, 0); chk("to_wait_req", bus_req, 1); nxt();
        end
        stall = 1;
        samp(); chk("to_err", err, 1); chk("to_busy", busy, 0); chk("to_rd_data", rd_data, 0); chk("to_req_last", bus_req, 1); nxt();
        samp(); chk("to_hold_err", err, 1); chk("to_hold_busy", busy, 0); chk("to_req_low", bus_req, 0); nxt();
        stall = 0;
        samp(); chk("to_hold_err2", err, 1); nxt();
        clr_in();
        samp(); chk("to_idle_err", err, 0); nxt();

        // posted-write timeout
        clr_in(); as = 1; rw = 1; addr = A_B3; be = 4'hF; wr_data = 32'h9999_0000;
        samp(); chk("pto_acc_busy", busy, 0); nxt();
        clr_in();
        for (int k = 0; k < 4; k++) begin
            samp(); chk("pto_busy", busy, 0); chk("pto_wr_err_early", wr_err, 0);
            chk("pto_err", err, 0); chk("pto_req", bus_req, 1); nxt();
        end
        samp(); chk("pto_wr_err", wr_err, 1); chk("pto_req_low", bus_req, 0); nxt();
        samp(); chk("pto_wr_err_pulse", wr_err, 0); nxt();

        // flush in REQ, together with grant
        clr_in(); as = 1; addr = A_B2;
        samp(); chk("frq_busy", busy, 1); nxt();
        flush = 1; bus_grnt = 1;
        samp(); chk("frq_req", bus_req, 1); nxt();
        clr_in();
        samp(); chk("frq_req_low", bus_req, 0); chk("frq_as", bus_as, 0); chk("frq_busy_idle", busy, 0); nxt();
        samp(); chk("frq_as_later", bus_as, 0); nxt();

        // flush in ACCESS: bus finishes, result discarded, no HOLD
        clr_in(); as = 1; addr = A_B2;
        samp(); nxt();
        bus_grnt = 1;
        samp(); nxt();
        bus_grnt = 0; flush = 1;
        samp(); chk("fac_as", bus_as, 1); chk("fac_rd0", rd_data, 0); nxt();
        flush = 0; bus_rdy = 1; bus_rd_data = 32'h7777_7777; stall = 1;
        samp(); chk("fac_rd_discard", rd_data, 0); chk("fac_req", bus_req, 1); chk("fac_err", err, 0); nxt();
        clr_in(); as = 1; addr = A_SPM; spm_rd_data = 32'h0000_1111;
        samp(); chk("fac_idle_spm_as", spm_as, 1); chk("fac_req_low", bus_req, 0); chk("fac_spm_data", rd_data, 32'h0000_1111); nxt();

        // asynchronous reset mid-ACCESS
        clr_in(); as = 1; addr = A_B2;
        samp(); nxt();
        bus_grnt = 1;
        samp(); nxt();
        bus_grnt = 0;
        samp(); chk("ars_pre_req", bus_req, 1); chk("ars_pre_as", bus_as, 1);
        as = 0; rst = 1;
        #1;
        chk("ars_req", bus_req, 0); chk("ars_as", bus_as, 0); chk("ars_addr", bus_addr, 0); chk("ars_busy", busy, 0);
        #1 rst = 0;
        nxt();
        as = 1; addr = A_SPM; spm_rd_data = 32'h4242_4242;
        samp(); chk("ars_idle_spm_as", spm_as, 1); chk("ars_idle_req", bus_req, 0); nxt();
        clr_in(); nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
